// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Holds the state encoding and the width helpers used by the top and by the bench.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } pll_state_t;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A zero-retry build still needs a 1-bit retry counter.
    function automatic int retry_w(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Control/status bundle between the PLL reset sequencer and its surroundings.
// The slave side is the sequencer; the master side drives lock and soft reset.
interface pll_reset_seq_if #(
    parameter int RETRY_W = 2
) ();
    import pll_seq_pkg::*;

    logic                  pll_locked;
    logic                  soft_rst_req;
    logic                  pll_rst;
    logic                  sys_rst_n;
    logic                  fail;
    logic [2:0]            state_o;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output pll_rst,
        output sys_rst_n,
        output fail,
        output state_o,
        output retry_cnt,
        output loss_cnt
    );

    modport master (
        output pll_locked,
        output soft_rst_req,
        input  pll_rst,
        input  sys_rst_n,
        input  fail,
        input  state_o,
        input  retry_cnt,
        input  loss_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, reset to zero.
// Also used in the 33.87 MHz domain to bring in sys_rst_n.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer on refclk: holds the PLL in reset, waits for a stable lock,
// then releases the downstream domain; re-sequences on loss, timeout or soft request.
//   state       | meaning
//   S_PLL_RST   | pll_rst high for POR_CYCLES
//   S_WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT_CYCLES
//   S_STABLE    | lock must hold LOCK_STABLE_CYCLES in a row
//   S_RUN       | sys_rst_n released, watching for lock loss
//   S_FAIL      | retries exhausted, parked until soft_rst_req
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int POR_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic            refclk,
    input  logic            rst_n,
    pll_reset_seq_if.slave  bus
);

    localparam int CNT_W   = $clog2(max3(POR_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;
    localparam int RETRY_W = retry_w(MAX_RETRIES);

    localparam logic [CNT_W-1:0]   POR_LAST     = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    pll_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  pll_rst_q, sys_rst_n_q, fail_q;
    logic                  locked_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (bus.pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == S_PLL_RST);
            sys_rst_n_q <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        // Soft request outranks everything, including a same-cycle lock loss.
        if (bus.soft_rst_req) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == POR_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_PLL_RST;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d = S_PLL_RST;
                        cnt_d   = '0;
                        if (loss_q != '1) begin
                            loss_d = loss_q + LOSS_CNT_W'(1);
                        end
                    end
                end
                S_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.fail      = fail_q;
    assign bus.state_o   = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with POR=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2.
// Expected values are hand-derived edge counts from the sequencing rules.
module tb_pll_reset_seq;
    import pll_seq_pkg::*;

    logic refclk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    pll_reset_seq_if #(.RETRY_W(2)) bus ();

    pll_reset_seq #(
        .POR_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic soft_pulse();
        bus.soft_rst_req = 1'b1;
        step(1);
        bus.soft_rst_req = 1'b0;
    endtask

    // Lock drop seen by the FSM 3 edges after the pin falls; relock reaches S_RUN 13 edges later.
    task automatic lose_and_relock();
        bus.pll_locked = 1'b0;
        step(3);
        bus.pll_locked = 1'b1;
        step(13);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n            = 1'b0;
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;

        // reset values
        #23;
        chk("rst_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("rst_pll_rst", 32'(bus.pll_rst), 1);
        chk("rst_sys_rst_n", 32'(bus.sys_rst_n), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_retry", 32'(bus.retry_cnt), 0);
        chk("rst_loss", 32'(bus.loss_cnt), 0);
        rst_n = 1'b1;

        // power-up: POR pulse of 4, lock captured at edge 4, STABLE at 6, RUN at 14
        step(3);
        chk("pu_por3_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("pu_por3_pll_rst", 32'(bus.pll_rst), 1);
        bus.pll_locked = 1'b1;
        step(1);
        chk("pu_wait_state", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        chk("pu_wait_pll_rst", 32'(bus.pll_rst), 0);
        step(1);
        chk("pu_wait2_state", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        step(1);
        chk("pu_stable_state", 32'(bus.state_o), 32'(S_STABLE));
        step(7);
        chk("pu_stable7_state", 32'(bus.state_o), 32'(S_STABLE));
        chk("pu_stable7_sys", 32'(bus.sys_rst_n), 0);
        step(1);
        chk("pu_run_state", 32'(bus.state_o), 32'(S_RUN));
        chk("pu_run_sys", 32'(bus.sys_rst_n), 1);
        chk("pu_run_retry", 32'(bus.retry_cnt), 0);

        // lock loss in S_RUN
        bus.pll_locked = 1'b0;
        step(2);
        chk("loss_pre_state", 32'(bus.state_o), 32'(S_RUN));
        chk("loss_pre_sys", 32'(bus.sys_rst_n), 1);
        step(1);
        chk("loss_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("loss_sys", 32'(bus.sys_rst_n), 0);
        chk("loss_cnt1", 32'(bus.loss_cnt), 1);
        chk("loss_pll_rst", 32'(bus.pll_rst), 1);
        bus.pll_locked = 1'b1;
        step(3);
        chk("loss_por3_pll_rst", 32'(bus.pll_rst), 1);
        step(1);
        chk("loss_wait_pll_rst", 32'(bus.pll_rst), 0);
        step(1);
        chk("loss_stable_state", 32'(bus.state_o), 32'(S_STABLE));
        step(8);
        chk("loss_relock_state", 32'(bus.state_o), 32'(S_RUN));
        chk("loss_relock_sys", 32'(bus.sys_rst_n), 1);

        // soft request in the same FSM cycle as a lock loss
        bus.pll_locked = 1'b0;
        step(2);
        soft_pulse();
        chk("soft_loss_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("soft_loss_cnt", 32'(bus.loss_cnt), 1);
        chk("soft_loss_retry", 32'(bus.retry_cnt), 0);
        chk("soft_loss_sys", 32'(bus.sys_rst_n), 0);
        bus.pll_locked = 1'b1;
        step(13);
        chk("soft_relock_state", 32'(bus.state_o), 32'(S_RUN));

        // loss counter saturation over 300 total losses
        for (int i = 0; i < 254; i++) lose_and_relock();
        chk("sat_255", 32'(bus.loss_cnt), 255);
        chk("sat_run_state", 32'(bus.state_o), 32'(S_RUN));
        for (int i = 0; i < 45; i++) lose_and_relock();
        chk("sat_hold", 32'(bus.loss_cnt), 255);
        chk("sat_hold_sys", 32'(bus.sys_rst_n), 1);

        // unstable lock: one timeout first so retry_cnt is non-zero
        bus.pll_locked = 1'b0;
        step(3);
        chk("un_loss_state", 32'(bus.state_o), 32'(S_PLL_RST));
        step(4);
        step(32);
        chk("un_retry1_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("un_retry1", 32'(bus.retry_cnt), 1);
        step(4);
        chk("un_wait_state", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        bus.pll_locked = 1'b1;
        step(3);
        chk("un_stable_state", 32'(bus.state_o), 32'(S_STABLE));
        step(2);
        bus.pll_locked = 1'b0;
        step(3);
        chk("un_back_wait", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        chk("un_back_retry", 32'(bus.retry_cnt), 1);
        chk("un_back_sys", 32'(bus.sys_rst_n), 0);
        bus.pll_locked = 1'b1;
        step(3);
        chk("un_stable2_state", 32'(bus.state_o), 32'(S_STABLE));
        step(7);
        chk("un_stable2_sys", 32'(bus.sys_rst_n), 0);
        step(1);
        chk("un_run_state", 32'(bus.state_o), 32'(S_RUN));
        chk("un_run_sys", 32'(bus.sys_rst_n), 1);
        chk("un_run_retry", 32'(bus.retry_cnt), 0);

        // no lock: two retries, then S_FAIL
        bus.pll_locked = 1'b0;
        step(3);
        step(4);
        chk("nl_wait0_state", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        chk("nl_wait0_retry", 32'(bus.retry_cnt), 0);
        step(32);
        chk("nl_r1_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("nl_r1_retry", 32'(bus.retry_cnt), 1);
        chk("nl_r1_pll_rst", 32'(bus.pll_rst), 1);
        step(3);
        chk("nl_r1_por3", 32'(bus.pll_rst), 1);
        step(1);
        chk("nl_r1_wait", 32'(bus.pll_rst), 0);
        step(32);
        chk("nl_r2_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("nl_r2_retry", 32'(bus.retry_cnt), 2);
        step(4);
        step(31);
        chk("nl_last_wait", 32'(bus.state_o), 32'(S_WAIT_LOCK));
        step(1);
        chk("nl_fail_state", 32'(bus.state_o), 32'(S_FAIL));
        chk("nl_fail", 32'(bus.fail), 1);
        chk("nl_fail_sys", 32'(bus.sys_rst_n), 0);
        chk("nl_fail_pll_rst", 32'(bus.pll_rst), 0);
        step(5);
        chk("nl_fail_hold", 32'(bus.state_o), 32'(S_FAIL));
        soft_pulse();
        chk("nl_soft_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("nl_soft_fail", 32'(bus.fail), 0);
        chk("nl_soft_retry", 32'(bus.retry_cnt), 0);
        chk("nl_soft_pll_rst", 32'(bus.pll_rst), 1);
        step(2);
        soft_pulse();
        step(3);
        chk("nl_por_restart", 32'(bus.state_o), 32'(S_PLL_RST));
        step(1);
        chk("nl_por_done", 32'(bus.state_o), 32'(S_WAIT_LOCK));

        // async reset in the middle of S_STABLE
        bus.pll_locked = 1'b1;
        step(3);
        chk("ar_stable_state", 32'(bus.state_o), 32'(S_STABLE));
        step(2);
        rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state_o), 32'(S_PLL_RST));
        chk("ar_pll_rst", 32'(bus.pll_rst), 1);
        chk("ar_sys", 32'(bus.sys_rst_n), 0);
        chk("ar_loss", 32'(bus.loss_cnt), 0);
        chk("ar_retry", 32'(bus.retry_cnt), 0);
        rst_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
